// File: rtl/bp_axi4_burst_pkg.sv
// bp_axi4_burst_pkg: shared state, packet and AXI encodings for the DMA-to-AXI4 burst bridge
`define BP_AXI4_DMA_PKT_S(addr_width_mp) struct packed { logic write_not_read; logic [addr_width_mp-1:0] addr; }

package bp_axi4_burst_pkg;
  typedef enum logic [2:0] {e_idle, e_rd_addr, e_rd_data, e_wr, e_wr_resp} state_e;
  localparam logic [1:0] e_axi_burst_incr = 2'b01;
  typedef enum logic [1:0] {
    e_axi_resp_okay = 2'b00,
    e_axi_resp_exokay = 2'b01,
    e_axi_resp_slverr = 2'b10,
    e_axi_resp_decerr = 2'b11
  } axi_resp_e;
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp == e_axi_resp_slverr || resp == e_axi_resp_decerr;
  endfunction
endpackage

// File: rtl/bp_axi4_burst_watchdog.sv
// bp_axi4_burst_watchdog: saturating stall counter that pulses expire once when timeout_p is reached
module bp_axi4_burst_watchdog #(
  parameter int timeout_p = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int w_lp = timeout_p == 0 ? 1 : $clog2(timeout_p + 1);
  localparam logic [w_lp-1:0] lim_lp = w_lp'(timeout_p);
  logic [w_lp-1:0] cnt_r;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_r <= '0;
    else cnt_r <= clear ? '0 : (en && cnt_r != lim_lp) ? cnt_r + 1'b1 : cnt_r;
  // saturating at the limit keeps the pulse single while the stall persists
  assign expire = timeout_p != 0 && en && !clear && cnt_r == lim_lp - 1'b1;
endmodule

// File: rtl/bp_cache_dma_to_axi4_burst.sv
// bp_cache_dma_to_axi4_burst: turns one cache-block DMA packet into one AXI4 INCR burst
module bp_cache_dma_to_axi4_burst
  import bp_axi4_burst_pkg::*;
#(
  parameter int daddr_width_p = 32,
  parameter int axi_addr_width_p = 28,
  parameter int axi_data_width_p = 64,
  parameter int block_width_p = 512,
  parameter int timeout_p = 4096
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [daddr_width_p:0]        dma_pkt_i,
  input  logic                          dma_pkt_v_i,
  output logic                          dma_pkt_yumi_o,
  output logic [axi_data_width_p-1:0]   dma_data_o,
  output logic                          dma_data_v_o,
  input  logic                          dma_data_ready_and_i,
  input  logic [axi_data_width_p-1:0]   dma_data_i,
  input  logic                          dma_data_v_i,
  output logic                          dma_data_yumi_o,
  output logic [axi_addr_width_p-1:0]   m_axi_awaddr_o,
  output logic [7:0]                    m_axi_awlen_o,
  output logic [2:0]                    m_axi_awsize_o,
  output logic [1:0]                    m_axi_awburst_o,
  output logic                          m_axi_awvalid_o,
  input  logic                          m_axi_awready_i,
  output logic [axi_data_width_p-1:0]   m_axi_wdata_o,
  output logic [axi_data_width_p/8-1:0] m_axi_wstrb_o,
  output logic                          m_axi_wlast_o,
  output logic                          m_axi_wvalid_o,
  input  logic                          m_axi_wready_i,
  input  logic [1:0]                    m_axi_bresp_i,
  input  logic                          m_axi_bvalid_i,
  output logic                          m_axi_bready_o,
  output logic [axi_addr_width_p-1:0]   m_axi_araddr_o,
  output logic [7:0]                    m_axi_arlen_o,
  output logic [2:0]                    m_axi_arsize_o,
  output logic [1:0]                    m_axi_arburst_o,
  output logic                          m_axi_arvalid_o,
  input  logic                          m_axi_arready_i,
  input  logic [axi_data_width_p-1:0]   m_axi_rdata_i,
  input  logic [1:0]                    m_axi_rresp_i,
  input  logic                          m_axi_rlast_i,
  input  logic                          m_axi_rvalid_i,
  output logic                          m_axi_rready_o,
  output logic                          rd_error_o,
  output logic                          wr_error_o,
  output logic                          busy_o
);
  localparam int n_lp = block_width_p / axi_data_width_p;
  localparam int cnt_w_lp = $clog2(n_lp + 1);
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(n_lp - 1);
  typedef `BP_AXI4_DMA_PKT_S(daddr_width_p) dma_pkt_s;
  dma_pkt_s pkt;
  state_e state_r, state_n;
  logic [axi_addr_width_p-1:0] addr_r;
  logic [cnt_w_lp-1:0] beat_cnt_r;
  logic wnr_r, aw_done_r, w_done_r;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs, last_beat, wr_done, expire;
  logic unused;
  assign pkt = dma_pkt_i;
  // DMA address bits above the AXI window are dropped
  assign unused = ^pkt.addr;
  assign m_axi_awaddr_o = addr_r;
  assign m_axi_araddr_o = addr_r;
  assign m_axi_awlen_o = 8'(n_lp - 1);
  assign m_axi_arlen_o = 8'(n_lp - 1);
  assign m_axi_awsize_o = 3'($clog2(axi_data_width_p / 8));
  assign m_axi_arsize_o = 3'($clog2(axi_data_width_p / 8));
  assign m_axi_awburst_o = e_axi_burst_incr;
  assign m_axi_arburst_o = e_axi_burst_incr;
  assign m_axi_wstrb_o = '1;
  assign m_axi_wdata_o = dma_data_i;
  assign dma_data_o = m_axi_rdata_i;
  assign ar_hs = m_axi_arvalid_o && m_axi_arready_i;
  assign aw_hs = m_axi_awvalid_o && m_axi_awready_i;
  assign w_hs = m_axi_wvalid_o && m_axi_wready_i;
  assign r_hs = dma_data_v_o && m_axi_rready_o;
  assign b_hs = m_axi_bready_o && m_axi_bvalid_i;
  assign last_beat = beat_cnt_r == last_lp;
  // AW and the final W beat may finish in either order or together
  assign wr_done = (aw_done_r || aw_hs) && (w_done_r || (w_hs && last_beat));

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= e_idle;
    else state_r <= state_n;

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:    state_n = dma_pkt_v_i ? (pkt.write_not_read ? e_wr : e_rd_addr) : e_idle;
      e_rd_addr: state_n = m_axi_arready_i ? e_rd_data : e_rd_addr;
      e_rd_data: state_n = (r_hs && last_beat) ? e_idle : e_rd_data;
      e_wr:      state_n = wr_done ? e_wr_resp : e_wr;
      e_wr_resp: state_n = m_axi_bvalid_i ? e_idle : e_wr_resp;
      default:   state_n = e_idle;
    endcase
  end

  always_comb begin
    dma_pkt_yumi_o = reset_n_i && state_r == e_idle && dma_pkt_v_i;
    m_axi_arvalid_o = state_r == e_rd_addr;
    m_axi_rready_o = state_r == e_rd_data && dma_data_ready_and_i;
    dma_data_v_o = state_r == e_rd_data && m_axi_rvalid_i;
    m_axi_awvalid_o = state_r == e_wr && !aw_done_r;
    m_axi_wvalid_o = state_r == e_wr && dma_data_v_i && !w_done_r;
    m_axi_wlast_o = state_r == e_wr && last_beat;
    dma_data_yumi_o = m_axi_wvalid_o && m_axi_wready_i;
    m_axi_bready_o = state_r == e_wr_resp;
    busy_o = state_r != e_idle;
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      addr_r <= '0;
      wnr_r <= 1'b0;
      beat_cnt_r <= '0;
      aw_done_r <= 1'b0;
      w_done_r <= 1'b0;
      rd_error_o <= 1'b0;
      wr_error_o <= 1'b0;
    end else begin
      if (dma_pkt_yumi_o) begin
        addr_r <= pkt.addr[axi_addr_width_p-1:0];
        wnr_r <= pkt.write_not_read;
      end
      beat_cnt_r <= dma_pkt_yumi_o ? '0 : (r_hs || w_hs) ? beat_cnt_r + 1'b1 : beat_cnt_r;
      aw_done_r <= dma_pkt_yumi_o ? 1'b0 : aw_done_r || aw_hs;
      w_done_r <= dma_pkt_yumi_o ? 1'b0 : w_done_r || (w_hs && last_beat);
      rd_error_o <= rd_error_o || (r_hs && ((m_axi_rlast_i != last_beat) || resp_is_err(m_axi_rresp_i)))
                    || (expire && !wnr_r);
      wr_error_o <= wr_error_o || (b_hs && resp_is_err(m_axi_bresp_i)) || (expire && wnr_r);
    end

  bp_axi4_burst_watchdog #(.timeout_p(timeout_p)) watchdog (
    .clk(clk_i),
    .reset_n(reset_n_i),
    .clear(ar_hs || r_hs || aw_hs || w_hs || b_hs || !busy_o),
    .en(busy_o),
    .expire(expire)
  );
endmodule

// File: tb/tb_bp_cache_dma_to_axi4_burst.sv
// tb_bp_cache_dma_to_axi4_burst: directed stimulus with queue scoreboard for the AXI4 burst bridge
module tb_bp_cache_dma_to_axi4_burst;
  localparam int DAW = 32, AW = 28, DW = 64, BW = 512, N = BW / DW, TO = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n_i;
  logic [DAW:0] dma_pkt_i;
  logic dma_pkt_v_i, dma_pkt_yumi_o;
  logic [DW-1:0] dma_data_o, dma_data_i, m_axi_wdata_o, m_axi_rdata_i;
  logic dma_data_v_o, dma_data_ready_and_i, dma_data_v_i, dma_data_yumi_o;
  logic [AW-1:0] m_axi_awaddr_o, m_axi_araddr_o;
  logic [7:0] m_axi_awlen_o, m_axi_arlen_o, m_axi_wstrb_o;
  logic [2:0] m_axi_awsize_o, m_axi_arsize_o;
  logic [1:0] m_axi_awburst_o, m_axi_arburst_o, m_axi_bresp_i, m_axi_rresp_i;
  logic m_axi_awvalid_o, m_axi_awready_i, m_axi_wlast_o, m_axi_wvalid_o, m_axi_wready_i;
  logic m_axi_bvalid_i, m_axi_bready_o, m_axi_arvalid_o, m_axi_arready_i;
  logic m_axi_rlast_i, m_axi_rvalid_i, m_axi_rready_o, rd_error_o, wr_error_o, busy_o;
  logic tog;

  bp_cache_dma_to_axi4_burst #(.daddr_width_p(DAW), .axi_addr_width_p(AW), .axi_data_width_p(DW),
    .block_width_p(BW), .timeout_p(TO)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_and_i(dma_data_ready_and_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awlen_o(m_axi_awlen_o), .m_axi_awsize_o(m_axi_awsize_o),
    .m_axi_awburst_o(m_axi_awburst_o), .m_axi_awvalid_o(m_axi_awvalid_o), .m_axi_awready_i(m_axi_awready_i),
    .m_axi_wdata_o(m_axi_wdata_o), .m_axi_wstrb_o(m_axi_wstrb_o), .m_axi_wlast_o(m_axi_wlast_o),
    .m_axi_wvalid_o(m_axi_wvalid_o), .m_axi_wready_i(m_axi_wready_i),
    .m_axi_bresp_i(m_axi_bresp_i), .m_axi_bvalid_i(m_axi_bvalid_i), .m_axi_bready_o(m_axi_bready_o),
    .m_axi_araddr_o(m_axi_araddr_o), .m_axi_arlen_o(m_axi_arlen_o), .m_axi_arsize_o(m_axi_arsize_o),
    .m_axi_arburst_o(m_axi_arburst_o), .m_axi_arvalid_o(m_axi_arvalid_o), .m_axi_arready_i(m_axi_arready_i),
    .m_axi_rdata_i(m_axi_rdata_i), .m_axi_rresp_i(m_axi_rresp_i), .m_axi_rlast_i(m_axi_rlast_i),
    .m_axi_rvalid_i(m_axi_rvalid_i), .m_axi_rready_o(m_axi_rready_o),
    .rd_error_o(rd_error_o), .wr_error_o(wr_error_o), .busy_o(busy_o)
  );

  logic [AW-1:0] exp_ar[$], exp_aw[$];
  logic [DW-1:0] exp_fill[$];
  logic [DW:0] exp_w[$];
  int compared = 0, mismatched = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tfail(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: wait expired, got no handshake expected one within 50 cycles", nm);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_arvalid"}, m_axi_arvalid_o, 0);
    chk({nm, "_awvalid"}, m_axi_awvalid_o, 0);
    chk({nm, "_wvalid"}, m_axi_wvalid_o, 0);
    chk({nm, "_rready"}, m_axi_rready_o, 0);
    chk({nm, "_bready"}, m_axi_bready_o, 0);
    chk({nm, "_fill_v"}, dma_data_v_o, 0);
    chk({nm, "_evict_yumi"}, dma_data_yumi_o, 0);
    chk({nm, "_pkt_yumi"}, dma_pkt_yumi_o, 0);
    chk({nm, "_rd_err"}, rd_error_o, 0);
    chk({nm, "_wr_err"}, wr_error_o, 0);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    #1 check_idle("reset_pulse");
    @(negedge clk) reset_n_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic wnr, input logic [DAW-1:0] addr);
    dma_pkt_i = {wnr, addr};
    dma_pkt_v_i = 1'b1;
    @(negedge clk) chk("pkt_yumi", dma_pkt_yumi_o, 1);
    @(posedge clk);
    #1 dma_pkt_v_i = 1'b0;
  endtask

  task automatic do_read(input logic [DAW-1:0] addr, input logic [DW-1:0] base, input int ar_delay,
                         input int rlast_at, input int err_beat, input logic toggle);
    logic got;
    for (int i = 0; i < N; i++) exp_fill.push_back(base + DW'(i));
    exp_ar.push_back(addr[AW-1:0]);
    m_axi_arready_i = (ar_delay == 0);
    tog = toggle;
    send_pkt(1'b0, addr);
    if (ar_delay > 0) begin
      repeat (10) @(posedge clk);
      #1 chk("rd_err_before_timeout", rd_error_o, 0);
      repeat (ar_delay - 10) @(posedge clk);
      #1 chk("rd_err_after_timeout", rd_error_o, 1);
      chk("still_waiting_ar", m_axi_arvalid_o, 1);
      m_axi_arready_i = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = m_axi_arvalid_o && m_axi_arready_i;
    end
    if (!got) tfail("ar_wait");
    @(posedge clk);
    #1 m_axi_arready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_axi_rvalid_i = 1'b1;
      m_axi_rdata_i = base + DW'(i);
      m_axi_rlast_i = (i == rlast_at);
      m_axi_rresp_i = (i == err_beat) ? 2'b10 : 2'b00;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        got = m_axi_rready_o;
      end
      if (!got) tfail("r_wait");
      @(posedge clk);
      #1;
    end
    m_axi_rvalid_i = 1'b0;
    m_axi_rlast_i = 1'b0;
    m_axi_rresp_i = 2'b00;
    tog = 1'b0;
    @(negedge clk) chk("rd_back_idle", busy_o, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [DAW-1:0] addr, input logic [DW-1:0] base, input int aw_delay,
                          input logic [1:0] bresp);
    logic got;
    exp_aw.push_back(addr[AW-1:0]);
    for (int i = 0; i < N; i++) exp_w.push_back({i == N - 1, base + DW'(i)});
    m_axi_awready_i = 1'b0;
    send_pkt(1'b1, addr);
    fork
      begin
        logic wgot;
        for (int i = 0; i < N; i++) begin
          dma_data_v_i = 1'b1;
          dma_data_i = base + DW'(i);
          wgot = 1'b0;
          for (int k = 0; k < 50 && !wgot; k++) begin
            @(negedge clk);
            wgot = dma_data_yumi_o;
          end
          if (!wgot) tfail("w_wait");
          @(posedge clk);
          #1;
        end
        dma_data_v_i = 1'b0;
      end
      begin
        logic agot;
        repeat (aw_delay) @(posedge clk);
        #1 m_axi_awready_i = 1'b1;
        agot = 1'b0;
        for (int k = 0; k < 50 && !agot; k++) begin
          @(negedge clk);
          agot = m_axi_awvalid_o;
        end
        if (!agot) tfail("aw_wait");
        @(posedge clk);
        #1 m_axi_awready_i = 1'b0;
      end
    join
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = m_axi_bready_o;
    end
    if (!got) tfail("b_wait");
    @(posedge clk);
    #1 m_axi_bvalid_i = 1'b1;
    m_axi_bresp_i = bresp;
    @(negedge clk) chk("bready_with_bvalid", m_axi_bready_o, 1);
    @(posedge clk);
    #1 m_axi_bvalid_i = 1'b0;
    m_axi_bresp_i = 2'b00;
    @(negedge clk) chk("wr_back_idle", busy_o, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    dma_data_ready_and_i = 1'b1;
    forever begin
      @(posedge clk);
      #1 dma_data_ready_and_i = tog ? ~dma_data_ready_and_i : 1'b1;
    end
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW:0] w;
    logic [DW-1:0] f;
    forever begin
      @(negedge clk);
      if (reset_n_i) begin
        if (m_axi_arvalid_o && m_axi_arready_i) begin
          chk("ar_expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) begin
            a = exp_ar.pop_front();
            chk("araddr", m_axi_araddr_o, a);
          end
          chk("arlen", m_axi_arlen_o, 7);
          chk("arsize", m_axi_arsize_o, 3);
          chk("arburst", m_axi_arburst_o, 1);
        end
        if (m_axi_awvalid_o && m_axi_awready_i) begin
          chk("aw_expected", exp_aw.size() != 0, 1);
          if (exp_aw.size() != 0) begin
            a = exp_aw.pop_front();
            chk("awaddr", m_axi_awaddr_o, a);
          end
          chk("awlen", m_axi_awlen_o, 7);
          chk("awsize", m_axi_awsize_o, 3);
          chk("awburst", m_axi_awburst_o, 1);
        end
        if (m_axi_wvalid_o && m_axi_wready_i) begin
          chk("w_expected", exp_w.size() != 0, 1);
          if (exp_w.size() != 0) begin
            w = exp_w.pop_front();
            chk("wdata", m_axi_wdata_o, w[DW-1:0]);
            chk("wlast", m_axi_wlast_o, w[DW]);
          end
          chk("wstrb", m_axi_wstrb_o, 8'hff);
          chk("evict_yumi", dma_data_yumi_o, 1);
        end
        if (dma_data_v_o) chk("rready_mirror", m_axi_rready_o, dma_data_ready_and_i);
        if (dma_data_v_o && dma_data_ready_and_i) begin
          chk("fill_expected", exp_fill.size() != 0, 1);
          if (exp_fill.size() != 0) begin
            f = exp_fill.pop_front();
            chk("fill_data", dma_data_o, f);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got no end expected summary");
    $fatal(1);
  end

  initial begin
    logic got;
    tog = 1'b0;
    dma_pkt_i = '0;
    dma_pkt_v_i = 1'b0;
    dma_data_i = '0;
    dma_data_v_i = 1'b0;
    m_axi_awready_i = 1'b0;
    m_axi_wready_i = 1'b1;
    m_axi_bresp_i = 2'b00;
    m_axi_bvalid_i = 1'b0;
    m_axi_arready_i = 1'b0;
    m_axi_rdata_i = '0;
    m_axi_rresp_i = 2'b00;
    m_axi_rlast_i = 1'b0;
    m_axi_rvalid_i = 1'b0;
    reset_n_i = 1'b1;
    #1 reset_n_i = 1'b0;
    #2 check_idle("por");
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    @(posedge clk);
    #1;
    do_read(32'h0000_0100, 64'hA000_0000_0000_0000, 0, N - 1, -1, 1'b0);
    chk("rd_clean_err", rd_error_o, 0);
    do_write(32'h0000_0200, 64'hB000_0000_0000_0010, 3, 2'b00);
    chk("wr_clean_err", wr_error_o, 0);
    do_write(32'hF123_4540, 64'hC000_0000_0000_0020, 10, 2'b00);
    chk("wr_late_aw_err", wr_error_o, 0);
    do_read(32'h0000_0380, 64'hD000_0000_0000_0030, 0, N - 1, -1, 1'b1);
    chk("rd_toggle_err", rd_error_o, 0);
    do_read(32'h0000_0400, 64'h1111_0000_0000_0000, 0, 5, -1, 1'b0);
    chk("rlast_early_rd_err", rd_error_o, 1);
    chk("rlast_early_wr_err", wr_error_o, 0);
    do_write(32'h0000_0440, 64'h2222_0000_0000_0000, 2, 2'b10);
    chk("bresp_slverr_wr_err", wr_error_o, 1);
    do_read(32'h0000_0480, 64'h3333_0000_0000_0000, 0, N - 1, -1, 1'b0);
    chk("sticky_rd_err", rd_error_o, 1);
    chk("sticky_wr_err", wr_error_o, 1);
    do_reset();
    do_read(32'h0000_04C0, 64'h4444_0000_0000_0000, 0, N - 1, 2, 1'b0);
    chk("rresp_slverr_rd_err", rd_error_o, 1);
    chk("rresp_slverr_wr_err", wr_error_o, 0);
    do_reset();
    do_read(32'h0000_0500, 64'h5555_0000_0000_0000, 20, N - 1, -1, 1'b0);
    chk("timeout_wr_err", wr_error_o, 0);
    do_reset();
    for (int i = 0; i < N; i++) exp_fill.push_back(64'h6666_0000_0000_0000 + DW'(i));
    exp_ar.push_back(28'h0000_300);
    m_axi_arready_i = 1'b1;
    send_pkt(1'b0, 32'h0000_0300);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = m_axi_arvalid_o && m_axi_arready_i;
    end
    if (!got) tfail("ar_wait_mid");
    @(posedge clk);
    #1 m_axi_arready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_axi_rvalid_i = 1'b1;
      m_axi_rdata_i = 64'h6666_0000_0000_0000 + DW'(i);
      m_axi_rlast_i = 1'b0;
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    chk("mid_fill_v_before_reset", dma_data_v_o, 1);
    #3 reset_n_i = 1'b0;
    #1 check_idle("mid_burst_reset");
    exp_fill.delete();
    m_axi_rvalid_i = 1'b0;
    @(negedge clk) reset_n_i = 1'b1;
    @(posedge clk);
    #1;
    do_read(32'h0000_0600, 64'h7777_0000_0000_0000, 0, N - 1, -1, 1'b0);
    chk("post_reset_rd_err", rd_error_o, 0);
    chk("drain_ar", exp_ar.size(), 0);
    chk("drain_aw", exp_aw.size(), 0);
    chk("drain_w", exp_w.size(), 0);
    chk("drain_fill", exp_fill.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bp_cache_dma_to_axi4_burst.md
Name: bp_cache_dma_to_axi4_burst

Overview:
- Next-generation bridge between the BlackParrot unicore cache DMA interface and DDR, replacing the single-beat AXI4-Lite converter.
- Each cache-block DMA request becomes one AXI4 INCR burst, so a full block moves in one address handshake plus N data beats.
- Widths, block size and the stall watchdog are parametrised.
- Sits between bp_unicore DMA ports and the MIG AXI4 slave.

Parameters:
- daddr_width_p, 32, DMA packet address width.
- axi_addr_width_p, 28, AXI address width; the DMA address is truncated to its low bits.
- axi_data_width_p, 64, AXI data width; equals the L2 fill width. Legal values: 64, 128, 256.
- block_width_p, 512, cache block bits. Burst length N = block_width_p/axi_data_width_p, with 1 ≤ N ≤ 256.
- timeout_p, 4096, idle-handshake cycles before the stall error fires. 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- dma_pkt_i  in  1+daddr_width_p  {write_not_read, addr}; addr is block-aligned.
- dma_pkt_v_i / dma_pkt_yumi_o  in/out  1  packet valid / packet consumed.
- dma_data_o  out  axi_data_width_p  read fill beat to the cache.
- dma_data_v_o / dma_data_ready_and_i  out/in  1  fill valid / fill ready.
- dma_data_i  in  axi_data_width_p  evict beat from the cache.
- dma_data_v_i / dma_data_yumi_o  in/out  1  evict valid / evict consumed.
- m_axi_awaddr_o / m_axi_araddr_o  out  axi_addr_width_p  burst addresses.
- m_axi_awlen_o / m_axi_arlen_o  out  8  N-1.
- m_axi_awsize_o / m_axi_arsize_o  out  3  log2(axi_data_width_p/8).
- m_axi_awburst_o / m_axi_arburst_o  out  2  constant 2'b01 (INCR).
- m_axi_awvalid_o, m_axi_awready_i, m_axi_arvalid_o, m_axi_arready_i  out/in/out/in  1  address handshakes.
- m_axi_wdata_o  out  axi_data_width_p  write beat.
- m_axi_wstrb_o  out  axi_data_width_p/8  all ones.
- m_axi_wlast_o, m_axi_wvalid_o, m_axi_wready_i  out/out/in  1  write data channel.
- m_axi_bresp_i  in  2  write response code.
- m_axi_bvalid_i, m_axi_bready_o  in/out  1  write response handshake.
- m_axi_rdata_i  in  axi_data_width_p  read beat.
- m_axi_rresp_i  in  2  read response code.
- m_axi_rlast_i, m_axi_rvalid_i, m_axi_rready_o  in/in/out  1  read data channel.
- rd_error_o, wr_error_o  out  1  sticky error flags.
- busy_o  out  1  state != e_idle.

Behaviour:
- Reset (async assert, sync deassert externally guaranteed): state = e_idle; all valids, yumis, readies, busy_o and error flags = 0; counters = 0.
  - An in-flight burst is abandoned; this is a system-wide reset only.
- One transaction outstanding at a time. FSM: e_idle, e_rd_addr, e_rd_data, e_wr, e_wr_resp.
- e_idle:
  - dma_pkt_yumi_o = dma_pkt_v_i, combinational.
  - Packet address and write_not_read are registered on yumi.
  - Next state is e_wr if write, else e_rd_addr. Valid appears on the AXI channel the cycle after yumi.
- e_rd_addr: arvalid = 1 with registered address. On arready go to e_rd_data.
- e_rd_data:
  - Pass-through: dma_data_o = rdata, dma_data_v_o = rvalid, rready = dma_data_ready_and_i. Zero added latency.
  - Beat counter increments on each rvalid & rready.
  - On the Nth beat go to e_idle.
  - rlast must coincide with beat N-1 (0-indexed); a mismatch sets rd_error_o.
  - rresp[1] = 1 on any beat sets rd_error_o. Data is still forwarded.
- e_wr: AW and W are independent.
  - awvalid = !aw_done_r.
  - wvalid = dma_data_v_i & !w_done_r; wdata = dma_data_i.
  - dma_data_yumi_o = wvalid & wready.
  - wlast = (beat_cnt == N-1).
  - W beats may precede the AW handshake.
  - When aw_done and the last W beat are both done (same cycle allowed) go to e_wr_resp.
- e_wr_resp: bready = 1. On bvalid go to e_idle; bresp[1] = 1 sets wr_error_o.
- Watchdog:
  - A counter clears on any AXI handshake and on entry to e_idle.
  - It increments otherwise while busy.
  - Reaching timeout_p sets rd_error_o or wr_error_o per the current direction. State is unchanged; the FSM keeps waiting.
- Error flags clear only on reset.
- Counters are sized $clog2(N+1) and never wrap within a burst.
- N = 1: wlast is asserted on the single beat.

Decomposition:
- Package bp_axi4_burst_pkg holds:
  - state enum;
  - dma packet struct {write_not_read, addr} via a width macro;
  - AXI constants: e_axi_burst_incr = 2'b01, e_axi_resp_okay = 2'b00, SLVERR and DECERR codes.
- One sub-module is natural: bp_axi4_burst_watchdog (counter, clear, enable, expire pulse).

Test Plan:
- Read at 0x0000_0100, N = 8, zero-latency slave → araddr = 0x100, arlen = 7, arsize = 3, 8 beats forwarded in order, back in e_idle.
- Write with W data offered 3 cycles before awready → 8 W beats accepted early, wlast on beat 7, bvalid returns to idle, wr_error_o = 0.
- Read with dma_data_ready_and_i toggling 1-0-1 → rready mirrors it, no beat lost or duplicated.
- bresp = 2'b10 on a write; rlast on beat 5 of 8 on a read → wr_error_o = 1, and rd_error_o = 1 respectively; both stay set until reset.
- timeout_p = 16, arready withheld 20 cycles → rd_error_o rises at cycle 16; the read completes when arready arrives.
- reset_n_i low mid-read burst beat 3 → all outputs 0 asynchronously; after release a new read starts cleanly with beat_cnt = 0.
